// File: rtl/relu_layer_ctrl_pkg.sv
// Shared types and constants for the ReLU layer sequencer.
// Also used by the activation buffer to unpack wr_data lanes.
package relu_layer_ctrl_pkg;

  localparam int RELU_SIZE_DEF = 21;
  localparam int LANES = 4;

  // Lane offsets within a packed activation word (lane0 in LSBs)
  localparam int LANE0_LSB = 0;
  localparam int LANE1_LSB = 1 * RELU_SIZE_DEF;
  localparam int LANE2_LSB = 2 * RELU_SIZE_DEF;
  localparam int LANE3_LSB = 3 * RELU_SIZE_DEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_ISSUE,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_e;

  function automatic int lane_lsb(input int lane, input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/relu_layer_ctrl.sv
// Packs a serial accumulator stream into 4-lane groups, drives the
// registered ReLU, and writes each result group into the activation
// buffer.
// Ports: clk/rst_n (sync, active low); start/num_neurons launch a pass;
// acc_valid/acc_data/acc_ready input stream; relu_in_ready/relu_in0..3
// and relu_ready/relu_out0..3 to/from ReLU; wr_en/wr_addr/wr_data/
// wr_mask buffer write; busy/done status.
module relu_layer_ctrl
  import relu_layer_ctrl_pkg::*;
#(
  parameter int RELU_SIZE       = RELU_SIZE_DEF,
  parameter int NUM_NEURONS_MAX = 64,
  parameter int CNT_W           = 7,
  parameter int GRP_W           = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [CNT_W-1:0]           num_neurons,
  input  logic                       acc_valid,
  input  logic [RELU_SIZE-1:0]       acc_data,
  output logic                       acc_ready,
  output logic                       relu_in_ready,
  output logic [RELU_SIZE-1:0]       relu_in0,
  output logic [RELU_SIZE-1:0]       relu_in1,
  output logic [RELU_SIZE-1:0]       relu_in2,
  output logic [RELU_SIZE-1:0]       relu_in3,
  input  logic                       relu_ready,
  input  logic [RELU_SIZE-1:0]       relu_out0,
  input  logic [RELU_SIZE-1:0]       relu_out1,
  input  logic [RELU_SIZE-1:0]       relu_out2,
  input  logic [RELU_SIZE-1:0]       relu_out3,
  output logic                       wr_en,
  output logic [GRP_W-1:0]           wr_addr,
  output logic [LANES*RELU_SIZE-1:0] wr_data,
  output logic [LANES-1:0]           wr_mask,
  output logic                       busy,
  output logic                       done
);

  localparam logic [CNT_W-1:0] NMAX = CNT_W'(NUM_NEURONS_MAX);

  state_e                     r_state;
  logic [CNT_W-1:0]           r_num;
  logic [CNT_W-1:0]           r_cnt;
  logic [GRP_W-1:0]           r_grp;
  logic [GRP_W-1:0]           r_wr_addr;
  logic [1:0]                 r_lane_idx;
  logic [LANES-1:0]           r_mask;
  logic [LANES-1:0]           r_wr_mask;
  logic [RELU_SIZE-1:0]       r_lane [LANES];
  logic [RELU_SIZE-1:0]       r_relu_in [LANES];
  logic [LANES*RELU_SIZE-1:0] r_wr_data;
  logic                       r_busy;
  logic                       r_acc_ready;
  logic                       r_relu_in_ready;
  logic                       r_wr_en;
  logic                       r_done;

  state_e                     w_state_nxt;
  logic                       w_acc_fire;
  logic                       w_grp_last;
  logic [CNT_W-1:0]           w_cnt_inc;
  logic [RELU_SIZE-1:0]       w_lane_nxt [LANES];
  logic [RELU_SIZE-1:0]       w_relu_out [LANES];

  assign w_relu_out[0] = relu_out0;
  assign w_relu_out[1] = relu_out1;
  assign w_relu_out[2] = relu_out2;
  assign w_relu_out[3] = relu_out3;

  always_comb begin
    w_acc_fire = (r_state == S_GATHER) && acc_valid;
    w_cnt_inc  = r_cnt + 1'b1;
    w_grp_last = (r_lane_idx == 2'd3) || (w_cnt_inc == r_num);
    for (int i = 0; i < LANES; i++) begin
      w_lane_nxt[i] = r_lane[i];
      if (w_acc_fire && (r_lane_idx == 2'(i)))
        w_lane_nxt[i] = acc_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:
        if (start)
          w_state_nxt = (num_neurons == '0) ? S_DONE : S_GATHER;
      S_GATHER:
        if (w_acc_fire && w_grp_last)
          w_state_nxt = S_ISSUE;
      S_ISSUE:
        w_state_nxt = S_WAIT;
      S_WAIT:
        if (relu_ready)
          w_state_nxt = S_WRITE;
      S_WRITE:
        w_state_nxt = (r_cnt == r_num) ? S_DONE : S_GATHER;
      S_DONE:
        w_state_nxt = S_IDLE;
      default:
        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_num           <= '0;
      r_cnt           <= '0;
      r_grp           <= '0;
      r_wr_addr       <= '0;
      r_lane_idx      <= '0;
      r_mask          <= '0;
      r_wr_mask       <= '0;
      r_wr_data       <= '0;
      r_busy          <= 1'b0;
      r_acc_ready     <= 1'b0;
      r_relu_in_ready <= 1'b0;
      r_wr_en         <= 1'b0;
      r_done          <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_lane[i]    <= '0;
        r_relu_in[i] <= '0;
      end
    end else begin
      r_state         <= w_state_nxt;
      r_busy          <= (w_state_nxt != S_IDLE);
      r_acc_ready     <= (w_state_nxt == S_GATHER);
      r_relu_in_ready <= (w_state_nxt == S_ISSUE);
      r_wr_en         <= (w_state_nxt == S_WRITE);
      r_done          <= (w_state_nxt == S_DONE);
      unique case (r_state)
        S_IDLE:
          if (start) begin
            // Clamp illegal counts so the group index cannot wrap
            r_num <= (num_neurons > NMAX) ? NMAX : num_neurons;
            r_cnt      <= '0;
            r_grp      <= '0;
            r_lane_idx <= '0;
            r_mask     <= '0;
            for (int i = 0; i < LANES; i++)
              r_lane[i] <= '0;
          end
        S_GATHER:
          if (w_acc_fire) begin
            r_lane               <= w_lane_nxt;
            r_mask[r_lane_idx]   <= 1'b1;
            r_lane_idx           <= r_lane_idx + 1'b1;
            r_cnt                <= w_cnt_inc;
            // Lanes are zeroed per group, so unfilled lanes issue as 0
            if (w_grp_last)
              r_relu_in <= w_lane_nxt;
          end
        S_WAIT:
          if (relu_ready) begin
            for (int i = 0; i < LANES; i++)
              r_wr_data[lane_lsb(i, RELU_SIZE) +: RELU_SIZE]
                <= w_relu_out[i];
            r_wr_addr <= r_grp;
            r_wr_mask <= r_mask;
          end
        S_WRITE: begin
          r_grp      <= r_grp + 1'b1;
          r_lane_idx <= '0;
          r_mask     <= '0;
          for (int i = 0; i < LANES; i++)
            r_lane[i] <= '0;
        end
        default: ;
      endcase
    end
  end

  assign acc_ready     = r_acc_ready;
  assign relu_in_ready = r_relu_in_ready;
  assign relu_in0      = r_relu_in[0];
  assign relu_in1      = r_relu_in[1];
  assign relu_in2      = r_relu_in[2];
  assign relu_in3      = r_relu_in[3];
  assign wr_en         = r_wr_en;
  assign wr_addr       = r_wr_addr;
  assign wr_data       = r_wr_data;
  assign wr_mask       = r_wr_mask;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_relu_layer_ctrl.sv
// Self-checking bench for relu_layer_ctrl with a behavioural ReLU and
// a group-level reference model of the expected buffer writes.
module tb_relu_layer_ctrl;

  localparam int W  = 21;
  localparam int CW = 7;
  localparam int GW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] num_neurons;
  logic          acc_valid;
  logic [W-1:0]  acc_data;
  logic          acc_ready;
  logic          relu_in_ready;
  logic [W-1:0]  relu_in0, relu_in1, relu_in2, relu_in3;
  logic          relu_ready;
  logic [W-1:0]  relu_out0 = '0;
  logic [W-1:0]  relu_out1 = '0;
  logic [W-1:0]  relu_out2 = '0;
  logic [W-1:0]  relu_out3 = '0;
  logic          wr_en;
  logic [GW-1:0] wr_addr;
  logic [4*W-1:0] wr_data;
  logic [3:0]    wr_mask;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  relu_layer_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_neurons(num_neurons),
    .acc_valid(acc_valid), .acc_data(acc_data),
    .acc_ready(acc_ready),
    .relu_in_ready(relu_in_ready),
    .relu_in0(relu_in0), .relu_in1(relu_in1),
    .relu_in2(relu_in2), .relu_in3(relu_in3),
    .relu_ready(relu_ready),
    .relu_out0(relu_out0), .relu_out1(relu_out1),
    .relu_out2(relu_out2), .relu_out3(relu_out3),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask),
    .busy(busy), .done(done)
  );

  int n_err = 0;
  int n_chk = 0;
  int lat = 1;
  bit spur_en = 1'b0;
  logic [W-1:0] dat [64];

  function automatic logic [W-1:0] ref_relu(input logic [W-1:0] x);
    if ($signed(x) < 0) return '0;
    return x;
  endfunction

  // Registered ReLU with variable latency; may raise spurious
  // ready pulses while nothing is outstanding.
  int   m_pend = 0;
  logic m_ready = 1'b0;
  logic m_spur = 1'b0;
  assign relu_ready = m_ready | m_spur;

  always @(posedge clk) begin
    if (relu_in_ready) begin
      relu_out0 <= ref_relu(relu_in0);
      relu_out1 <= ref_relu(relu_in1);
      relu_out2 <= ref_relu(relu_in2);
      relu_out3 <= ref_relu(relu_in3);
      m_pend    <= lat;
      m_ready   <= (lat == 1);
      m_spur    <= 1'b0;
    end else begin
      if (m_pend > 1) begin
        m_pend  <= m_pend - 1;
        m_ready <= (m_pend == 2);
      end else begin
        m_pend  <= 0;
        m_ready <= 1'b0;
      end
      m_spur <= spur_en && (m_pend == 0)
                && ($urandom_range(0, 3) == 0);
    end
  end

  always @(posedge clk)
    if (rst_n === 1'b1 && start === 1'b1)
      assert (num_neurons <= 7'd64)
        else $error("illegal num_neurons %0d", num_neurons);

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4*W-1:0] exp_word(input int n, input int g);
    logic [4*W-1:0] w;
    w = '0;
    for (int i = 0; i < 4; i++)
      if (4 * g + i < n) w[i*W +: W] = ref_relu(dat[4*g+i]);
    return w;
  endfunction

  function automatic logic [3:0] exp_mask(input int n, input int g);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++)
      if (4 * g + i < n) m[i] = 1'b1;
    return m;
  endfunction

  // mode: 0 = valid every cycle, 1 = random gaps, 2 = fixed toggle
  task automatic run_pass(input int n, input int mode,
                          input bit mid_start, input bit abort);
    int acc_i, nwr, cyc, last_acc, last_wr, n_iss, iss_cyc, pat_i;
    bit fin, v;
    logic [W-1:0] lanes [4];
    logic [6:0] pat;
    acc_i = 0; nwr = 0; n_iss = 0; pat_i = 0;
    last_acc = -100; last_wr = -100; iss_cyc = -100;
    fin = 1'b0;
    pat = 7'b1011001;
    @(negedge clk);
    start = 1'b1;
    num_neurons = CW'(n);
    acc_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    num_neurons = CW'($urandom_range(0, 64));
    cyc = 1;
    while (!fin && cyc < 3000) begin
      lanes = '{relu_in0, relu_in1, relu_in2, relu_in3};
      if (relu_in_ready) begin
        for (int i = 0; i < 4; i++)
          chk($sformatf("relu_in%0d_g%0d", i, n_iss), lanes[i],
              (4 * n_iss + i < n) ? dat[4*n_iss+i] : '0);
        n_iss++;
        iss_cyc = cyc;
      end
      if (abort && n_iss == 1 && cyc == iss_cyc + 1) begin
        rst_n = 1'b0;
        acc_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_done", done, 0);
        return;
      end
      if (wr_en) begin
        chk("wr_addr", wr_addr, nwr);
        chk("wr_mask", wr_mask, exp_mask(n, nwr));
        chk("wr_data", wr_data, exp_word(n, nwr));
        chk("wr_latency", cyc - last_acc, 2 + lat);
        nwr++;
        last_wr = cyc;
      end
      if (done) begin
        fin = 1'b1;
        if (n > 0) chk("done_after_wr", cyc - last_wr, 1);
        else chk("done_empty", (cyc >= 1 && cyc <= 2), 1);
      end
      if (n > 0 && acc_i == n && cyc == last_acc + 1)
        chk("acc_ready_low", acc_ready, 0);
      if (!fin) begin
        case (mode)
          0: v = 1'b1;
          1: v = ($urandom_range(0, 2) != 0);
          default: begin
            v = (pat_i < 7) ? pat[pat_i] : 1'b1;
            pat_i++;
          end
        endcase
        acc_valid = v && (acc_i < n);
        acc_data = acc_valid ? dat[acc_i] : W'($urandom);
        if (acc_valid && acc_ready) begin
          last_acc = cyc;
          acc_i++;
        end
        start = mid_start && (cyc == 3);
      end else begin
        // start during the done pulse must be ignored
        acc_valid = 1'b0;
        start = 1'b1;
        num_neurons = CW'($urandom_range(1, 64));
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    acc_valid = 1'b0;
    if (!fin) chk("done_timeout", 0, 1);
    chk("n_writes", nwr, (n + 3) / 4);
    chk("n_issues", n_iss, (n + 3) / 4);
    chk("n_accepts", acc_i, n);
    chk("idle_after", busy, 0);
  endtask

  initial begin
    int d8[8];
    int d5[5];
    d8 = '{5, -3, 0, -1, 7, -20, 100, 2};
    d5 = '{1, 2, 3, 4, -9};
    rst_n = 1'b0;
    start = 1'b0;
    acc_valid = 1'b0;
    acc_data = '0;
    num_neurons = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy0", busy, 0);
    chk("rst_acc_ready0", acc_ready, 0);
    chk("rst_relu_in_ready0", relu_in_ready, 0);
    chk("rst_wr_en0", wr_en, 0);
    chk("rst_done0", done, 0);
    chk("rst_wr_addr0", wr_addr, 0);
    chk("rst_wr_mask0", wr_mask, 0);
    chk("rst_wr_data0", wr_data, 0);
    chk("rst_relu_in0", relu_in0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) dat[i] = W'(d8[i]);
    run_pass(8, 0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) dat[i] = W'(d5[i]);
    run_pass(5, 0, 1'b0, 1'b0);
    run_pass(0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) dat[i] = W'($urandom);
    run_pass(4, 2, 1'b0, 1'b0);
    for (int i = 0; i < 64; i++) dat[i] = W'($urandom);
    run_pass(8, 0, 1'b1, 1'b0);
    run_pass(8, 0, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) dat[i] = W'($urandom);
    run_pass(4, 0, 1'b0, 1'b0);
    spur_en = 1'b1;
    for (int i = 0; i < 64; i++) dat[i] = W'($urandom);
    run_pass(64, 1, 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      lat = $urandom_range(1, 3);
      for (int i = 0; i < 64; i++) dat[i] = W'($urandom);
      run_pass($urandom_range(0, 20), $urandom_range(0, 2),
               1'($urandom_range(0, 1)), 1'b0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
